// File: rtl/ram1_arbiter_pkg.sv
// Shared types for the RAM1 SRAM arbiter: FSM state encoding, bus owner, widths.
package ram1_arbiter_pkg;

  localparam int unsigned Ram1AddrW = 18;
  localparam int unsigned WaitW     = 3;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  typedef enum logic {
    OwnerIf,
    OwnerMem
  } owner_e;

endpackage

// File: rtl/ram1_wait_timer.sv
// Down-counting wait timer for RD and WR_PULSE phases; done while the count is zero.
module ram1_wait_timer
  import ram1_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WaitW-1:0] load_val_i,
  input  logic             en_i,
  output logic             done_o
);

  logic [WaitW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ram1_arbiter.sv
// RAM1 SRAM bus owner: arbitrates IF fetches and MEM loads/stores, MEM first.
// Optional IF stall counter enabled by defining RAM1_STALL_CNT_EN.
module ram1_arbiter
  import ram1_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = Ram1AddrW,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              stall_if,
  output logic [15:0]       stall_cnt,
  output logic [ADDR_W-1:0] Ram1Addr,
  inout  wire  [DATA_W-1:0] Ram1Data,
  output logic              Ram1OE,
  output logic              Ram1WE,
  output logic              Ram1EN
);

  state_e            state_q;
  owner_e            owner_q;
  logic [DATA_W-1:0] wdata_q;
  logic              grant_mem, grant_if, drive;
  logic              timer_load, timer_done;
  logic [WaitW-1:0]  timer_val;

  always_comb begin
    grant_mem  = (state_q == StIdle) && mem_req;
    grant_if   = (state_q == StIdle) && !mem_req && if_req;
    timer_load = 1'b0;
    timer_val  = '0;
    if ((grant_mem && !mem_we) || grant_if) begin
      timer_load = 1'b1;
      timer_val  = WaitW'(RD_WAIT);
    end else if (state_q == StWrSetup) begin
      timer_load = 1'b1;
      timer_val  = WaitW'(WR_PULSE - 1);
    end
  end

  ram1_wait_timer u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .en_i       ((state_q == StRd) || (state_q == StWrPulse)),
    .done_o     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      owner_q   <= OwnerIf;
      wdata_q   <= '0;
      Ram1Addr  <= '0;
      Ram1EN    <= 1'b1;
      Ram1OE    <= 1'b1;
      Ram1WE    <= 1'b1;
      if_ack    <= 1'b0;
      mem_ack   <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
    end else begin
      if_ack  <= 1'b0;
      mem_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_mem) begin
            owner_q  <= OwnerMem;
            Ram1Addr <= mem_addr;
            wdata_q  <= mem_wdata;
            Ram1EN   <= 1'b0;
            if (mem_we) begin
              state_q <= StWrSetup;
            end else begin
              state_q <= StRd;
              Ram1OE  <= 1'b0;
            end
          end else if (grant_if) begin
            owner_q  <= OwnerIf;
            Ram1Addr <= if_addr;
            Ram1EN   <= 1'b0;
            Ram1OE   <= 1'b0;
            state_q  <= StRd;
          end
        end
        StRd: begin
          if (timer_done) begin
            if (owner_q == OwnerMem) begin
              mem_rdata <= Ram1Data;
              mem_ack   <= 1'b1;
            end else begin
              if_rdata <= Ram1Data;
              if_ack   <= 1'b1;
            end
            Ram1EN  <= 1'b1;
            Ram1OE  <= 1'b1;
            state_q <= StIdle;
          end
        end
        StWrSetup: begin
          Ram1WE  <= 1'b0;
          state_q <= StWrPulse;
        end
        StWrPulse: begin
          if (timer_done) begin
            Ram1WE  <= 1'b1;
            state_q <= StWrHold;
          end
        end
        StWrHold: begin
          Ram1EN  <= 1'b1;
          mem_ack <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // OE is high in every write state, so the bus is never driven against the SRAM.
  assign drive    = (state_q == StWrSetup) || (state_q == StWrPulse) || (state_q == StWrHold);
  assign Ram1Data = drive ? wdata_q : {DATA_W{1'bz}};

  assign stall_if = if_req & ~(((state_q != StIdle) && (owner_q == OwnerIf)) | if_ack);

`ifdef RAM1_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (stall_if && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ram1_arbiter.sv
// Scoreboard bench for ram1_arbiter: SRAM model, directed spec cases, random IF/MEM traffic.
module tb_ram1_arbiter;

  typedef struct {
    logic        we;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_ack, mem_req, mem_we, mem_ack, stall_if;
  logic [17:0] if_addr, mem_addr, Ram1Addr;
  logic [15:0] if_rdata, mem_rdata, mem_wdata, stall_cnt;
  logic        Ram1OE, Ram1WE, Ram1EN;
  wire  [15:0] Ram1Data;

  logic [15:0] sram    [256];
  logic [15:0] ref_mem [256];
  logic        load_sram;
  logic        probe_en;
  exp_t        if_q[$], mem_q[$];
  exp_t        mon_e;
  int          n_cmp = 0, n_fail = 0, stall_seen = 0;
  int          lat_a, oe_a, we_a, lat_b, oe_b, we_b, s0;
  logic [15:0] c0;

  always #5 clk = ~clk;

  ram1_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .stall_if  (stall_if),
    .stall_cnt (stall_cnt),
    .Ram1Addr  (Ram1Addr),
    .Ram1Data  (Ram1Data),
    .Ram1OE    (Ram1OE),
    .Ram1WE    (Ram1WE),
    .Ram1EN    (Ram1EN)
  );

  // Asynchronous SRAM model (low 8 address bits) plus a probe driver to detect a floating bus.
  wire sram_oe = !Ram1EN && !Ram1OE && Ram1WE;
  assign Ram1Data = probe_en ? 16'hA5A5 : (sram_oe ? sram[Ram1Addr[7:0]] : 16'bz);

  always @(negedge clk) begin
    if (load_sram) begin
      for (int i = 0; i < 256; i++) sram[i] <= ref_mem[i];
    end else if (!Ram1EN && !Ram1WE) begin
      sram[Ram1Addr[7:0]] <= Ram1Data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected response whenever the DUT acks.
  always @(negedge clk) begin
    if (!rst) begin
      if (stall_if) stall_seen++;
      check("oe_we_never_both_low", {31'h0, Ram1OE | Ram1WE}, 32'h1);
      if (if_ack) begin
        if (if_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL if_unexpected_ack: got ack, expected none");
        end else begin
          mon_e = if_q.pop_front();
          check("if_rdata", {16'h0, if_rdata}, {16'h0, mon_e.data});
        end
      end
      if (mem_ack) begin
        if (mem_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL mem_unexpected_ack: got ack, expected none");
        end else begin
          mon_e = mem_q.pop_front();
          if (!mon_e.we) check("mem_rdata", {16'h0, mem_rdata}, {16'h0, mon_e.data});
        end
      end
    end
  end

  // Issue one request at posedge+1 and wait (bounded) for its ack; returns at ack cycle +1.
  task automatic do_op(input bit is_mem, input bit we, input logic [17:0] a,
                       input logic [15:0] d, input bit keep,
                       output int lat, output int oe_low, output int we_low);
    bit done = 1'b0;
    lat = 0; oe_low = 0; we_low = 0;
    if (is_mem) begin
      mem_req = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d;
      mem_q.push_back('{we: we, data: (we ? d : ref_mem[a[7:0]])});
      if (we) ref_mem[a[7:0]] = d;
    end else begin
      if_req = 1'b1; if_addr = a;
      if_q.push_back('{we: 1'b0, data: ref_mem[a[7:0]]});
    end
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (!Ram1OE) oe_low++;
      if (!Ram1WE) we_low++;
      if (is_mem && we && !Ram1EN && Ram1OE)
        check("wr_data_stable", {16'h0, Ram1Data}, {16'h0, d});
      done = is_mem ? mem_ack : if_ack;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL ack_timeout: got no ack in %0d cycles, expected ack (is_mem=%0d)", lat, is_mem);
    end
    if (!keep) begin
      if (is_mem) mem_req = 1'b0;
      else if_req = 1'b0;
    end
  endtask

  task automatic check_bus_hiz(input string name);
    probe_en = 1'b1;
    #1;
    check(name, {16'h0, Ram1Data}, 32'h0000A5A5);
    probe_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; load_sram = 1'b1; probe_en = 1'b0;
    if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 16'($urandom);
    ref_mem[16] = 16'h0F0F;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    load_sram = 1'b0;
    check("rst_en", {31'h0, Ram1EN}, 32'h1);
    check("rst_oe", {31'h0, Ram1OE}, 32'h1);
    check("rst_we", {31'h0, Ram1WE}, 32'h1);
    check("rst_addr", {14'h0, Ram1Addr}, 32'h0);
    check("rst_acks", {30'h0, if_ack, mem_ack}, 32'h0);
    check("rst_rdata", {if_rdata, mem_rdata}, 32'h0);
    check("rst_stall_cnt", {16'h0, stall_cnt}, 32'h0);
    check_bus_hiz("rst_bus_hiz");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset while WE is low aborts the write
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 18'h0007F; mem_wdata = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (!Ram1WE) break;
    end
    check("midwr_we_low", {31'h0, Ram1WE}, 32'h0);
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #1;
    check("midwr_we", {31'h0, Ram1WE}, 32'h1);
    check("midwr_oe", {31'h0, Ram1OE}, 32'h1);
    check("midwr_en", {31'h0, Ram1EN}, 32'h1);
    check("midwr_acks", {30'h0, if_ack, mem_ack}, 32'h0);
    check_bus_hiz("midwr_bus_hiz");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Single IF read
    s0 = stall_seen;
    do_op(1'b0, 1'b0, 18'h00010, 16'h0, 1'b0, lat_a, oe_a, we_a);
    check("rd_latency", lat_a, 3);
    check("rd_oe_low_cycles", oe_a, 2);
    check("rd_stall_cycles", stall_seen - s0, 1);

    // Single MEM write
    do_op(1'b1, 1'b1, 18'h00000, 16'h000F, 1'b0, lat_a, oe_a, we_a);
    check("wr_latency", lat_a, 4);
    check("wr_we_low_cycles", we_a, 1);
    check("wr_oe_low_cycles", oe_a, 0);
    check("wr_sram_word0", {16'h0, sram[0]}, 32'h000F);

    // Collision: MEM read and IF read in the same cycle
    s0 = stall_seen;
    c0 = stall_cnt;
    fork
      do_op(1'b1, 1'b0, 18'h00000, 16'h0, 1'b0, lat_a, oe_a, we_a);
      do_op(1'b0, 1'b0, 18'h00010, 16'h0, 1'b0, lat_b, oe_b, we_b);
    join
    check("col_mem_latency", lat_a, 3);
    check("col_if_latency", lat_b, 6);
    check("col_stall_cycles", stall_seen - s0, 4);
`ifdef RAM1_STALL_CNT_EN
    check("col_stall_cnt", {16'h0, 16'(stall_cnt - c0)}, 32'd4);
`else
    check("col_stall_cnt", {16'h0, stall_cnt}, 32'h0);
`endif

    // Back-to-back SW then LW, no idle cycle between
    do_op(1'b1, 1'b1, 18'h00005, 16'h1234, 1'b1, lat_a, oe_a, we_a);
    check("b2b_sw_latency", lat_a, 4);
    do_op(1'b1, 1'b0, 18'h00005, 16'h0, 1'b0, lat_b, oe_b, we_b);
    check("b2b_lw_latency", lat_b, 3);

    // Random traffic: IF fetches from 128..255, MEM loads/stores in 0..126
    fork
      begin
        int l, o, w;
        for (int n = 0; n < 30; n++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          do_op(1'b0, 1'b0, 18'(128 + $urandom_range(0, 127)), 16'h0, 1'b0, l, o, w);
        end
      end
      begin
        int l, o, w;
        for (int n = 0; n < 40; n++) begin
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          do_op(1'b1, 1'($urandom_range(0, 1)), 18'($urandom_range(0, 126)),
                16'($urandom), 1'b0, l, o, w);
        end
      end
    join

    repeat (3) @(posedge clk);
    #1;
    check("if_queue_drained", if_q.size(), 0);
    check("mem_queue_drained", mem_q.size(), 0);
`ifdef RAM1_STALL_CNT_EN
    check("final_stall_cnt", {16'h0, stall_cnt}, stall_seen);
`else
    check("final_stall_cnt", {16'h0, stall_cnt}, 32'h0);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
